priority_encoder_32x5: RTL

PRIORITY_ENCODER_32X5 -- requirements
Module: priority_encoder_32x5

---
 rtl/priority_encoder_32x5_if.sv | 22 ++
 rtl/priority_encoder_32x5.sv | 99 +++++++++
 2 files changed

// File: rtl/priority_encoder_32x5_if.sv
// Request/beat bus for the 32-to-5 priority encoder: a vector goes in,
// one beat per set bit comes out in ascending index order.
interface priority_encoder_32x5_if;
   logic [31:0] in;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  out;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        none;

   modport master (
      output in, in_valid, out_ready,
      input  in_ready, out, out_valid, out_last, none
   );

   modport slave (
      input  in, in_valid, out_ready,
      output in_ready, out, out_valid, out_last, none
   );
endinterface

// File: rtl/priority_encoder_32x5.sv
// Captures a 32-bit request vector and reports the index of every set bit,
// lowest first, one registered beat per cycle; an all-zero vector gives a single none beat.
module priority_encoder_32x5 (
   input  logic                   clk,
   input  logic                   reset,
   priority_encoder_32x5_if.slave bus
);
   typedef enum logic {IDLE, SCAN} state_t;

   state_t      state, state_next;
   logic [31:0] pending, pending_next, remaining;
   logic [4:0]  out_next;
   logic        out_valid_next, out_last_next, none_next, in_ready_next;
   logic        capture, beat;

   function automatic logic [4:0] lowest_index(input logic [31:0] v);
      lowest_index = 5'd0;
      for (int i = 31; i >= 0; i--)
         if (v[i]) lowest_index = 5'(i);
   endfunction

   function automatic logic single_bit(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

   // in_ready is a register, so it is already 0 throughout SCAN and during reset
   assign capture   = bus.in_valid && bus.in_ready;
   assign beat      = bus.out_valid && bus.out_ready;
   assign remaining = pending & ~(32'd1 << bus.out);

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (capture)               state_next = SCAN;
         SCAN: if (beat && bus.out_last)  state_next = IDLE;
         default:                         state_next = IDLE;
      endcase
   end

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      pending_next   = pending;
      out_next       = bus.out;
      out_valid_next = bus.out_valid;
      out_last_next  = bus.out_last;
      none_next      = bus.none;
      in_ready_next  = (state_next == IDLE);
      case (state)
         IDLE: begin
            if (capture) begin
               pending_next   = bus.in;
               out_next       = lowest_index(bus.in);
               out_valid_next = 1'b1;
               out_last_next  = single_bit(bus.in) || (bus.in == 32'd0);
               none_next      = (bus.in == 32'd0);
            end
         end
         SCAN: begin
            if (beat) begin
               pending_next = remaining;
               if (bus.out_last) begin
                  out_next       = 5'd0;
                  out_valid_next = 1'b0;
                  out_last_next  = 1'b0;
                  none_next      = 1'b0;
               end else begin
                  out_next      = lowest_index(remaining);
                  out_last_next = single_bit(remaining);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending       <= 32'd0;
         bus.out       <= 5'd0;
         bus.out_valid <= 1'b0;
         bus.out_last  <= 1'b0;
         bus.none      <= 1'b0;
         bus.in_ready  <= 1'b0;
      end else begin
         pending       <= pending_next;
         bus.out       <= out_next;
         bus.out_valid <= out_valid_next;
         bus.out_last  <= out_last_next;
         bus.none      <= none_next;
         bus.in_ready  <= in_ready_next;
      end
   end
endmodule
